// File: rtl/md_unit.sv
// md_unit - multi-cycle multiply/divide unit for the execute stage.
//
// Runs MULT, MULTU, DIV and DIVU from the decoded alucontrol code and
// commits the 64-bit result into the HI/LO pair. While an op is in flight
// it holds the pipeline. Any other alucontrol code is ignored here.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   valid      execute-stage instruction present
//   alucontrol decoded ALU operation (8 bits)
//   srca       rs operand: dividend / multiplicand
//   srcb       rt operand: divisor / multiplier
//   flush      aborts an op in flight, blocks acceptance in IDLE
//   stall      combinational pipeline hold
//   done       registered one-cycle result-committed pulse
//   busy       registered, high whenever the state is not IDLE
//   hi, lo     HI/LO result registers
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for an MD request
// MUL   | one-cycle multiply, writes hi/lo on exit
// DIV   | 32 restoring radix-2 steps, writes hi/lo on the last one
// DONE  | result committed, done pulse, back to IDLE

module md_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [7:0]  alucontrol,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Op codes as assigned in defines.vh.
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] opa_q;       // multiplicand, or dividend/quotient shift register
  logic [31:0] opb_q;       // multiplier, or divisor magnitude
  logic [31:0] rem_q;       // partial remainder
  logic        is_signed_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic [4:0]  cnt_q;

  logic        is_mul;
  logic        is_div;
  logic        op_signed;
  logic        req;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [32:0] trial;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign is_mul    = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_MULTU_OP);
  assign is_div    = (alucontrol == EXE_DIV_OP)  || (alucontrol == EXE_DIVU_OP);
  assign op_signed = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_DIV_OP);
  assign req       = valid & (is_mul | is_div);

  // Reset also drops the hold so the pipeline is never stalled while in reset.
  assign stall = req & ~done & resetn;

  assign abs_a = (op_signed && srca[31]) ? (32'd0 - srca) : srca;
  assign abs_b = (op_signed && srcb[31]) ? (32'd0 - srcb) : srcb;

  // Low 64 bits of a 64x64 product of the extended operands is the
  // correct 32x32 product for both signed and unsigned operands.
  assign ext_a   = is_signed_q ? {{32{opa_q[31]}}, opa_q} : {32'd0, opa_q};
  assign ext_b   = is_signed_q ? {{32{opb_q[31]}}, opb_q} : {32'd0, opb_q};
  assign product = ext_a * ext_b;

  // Restoring step: bit 32 of the trial difference is the borrow. The
  // shifted remainder is below twice the divisor, so a kept difference
  // always fits back into 32 bits.
  assign trial   = {rem_q, opa_q[31]} - {1'b0, opb_q};
  assign rem_nx  = trial[32] ? {rem_q[30:0], opa_q[31]} : trial[31:0];
  assign quo_nx  = {opa_q[30:0], ~trial[32]};
  assign quo_fix = (is_signed_q && (sign_a_q ^ sign_b_q)) ? (32'd0 - quo_nx) : quo_nx;
  assign rem_fix = (is_signed_q && sign_a_q) ? (32'd0 - rem_nx) : rem_nx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      opa_q       <= 32'd0;
      opb_q       <= 32'd0;
      rem_q       <= 32'd0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      cnt_q       <= 5'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req && !flush) begin
            busy        <= 1'b1;
            is_signed_q <= op_signed;
            if (is_mul) begin
              opa_q <= srca;
              opb_q <= srcb;
              state <= S_MUL;
            end else if (srcb != 32'd0) begin
              opa_q    <= abs_a;
              opb_q    <= abs_b;
              sign_a_q <= srca[31];
              sign_b_q <= srcb[31];
              rem_q    <= 32'd0;
              cnt_q    <= 5'd0;
              state    <= S_DIV;
            end else begin
              lo    <= 32'hFFFF_FFFF;
              hi    <= srca;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_MUL: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            hi    <= product[63:32];
            lo    <= product[31:0];
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DIV: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            rem_q <= rem_nx;
            opa_q <= quo_nx;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              lo    <= quo_fix;
              hi    <= rem_fix;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
